vending_ctrl_param: RTL
=======================

// Module: vending_ctrl_param
// PURPOSE
//  Parametrised drink-vending controller: next generation of the coffee-machine FSM.
//  Accumulates coin credit, accepts a drink selection against a per-drink price table,
//  runs a per-drink timed ingredient recipe on N_ING valves, then returns change.
//  Also adds cancel/refund and coin rejection. Runs on the system clock with an internal second-tick divider.
// PARAMETERS
//  N_DRINKS     4                 number of selectable drinks
//  N_ING        5                 number of ingredient valves (water, coffee, milk, choco, sugar)
//  CREDIT_W     8                 credit/price/change width, units of 100 colones
//  MAX_CREDIT   11                max credit held; any coin that would exceed it is rejected
//  STEP_W       4                 width of one recipe time entry, in seconds
//  TICK_DIV     50_000_000        clk cycles per one-second tick
//  PRICE_TABLE  {8'd7,8'd5,8'd4,8'd3}  packed; drink d price = [d*CREDIT_W +: CREDIT_W]
//  RECIPE_TABLE (project default) packed; drink d ingr i secs = [(d*N_ING+i)*STEP_W +: STEP_W]
// PORTS
//  clk          in   1                system clock
//  rst          in   1                asynchronous reset, active-low
//  coin_valid   in   1                1-cycle strobe, coin inserted
//  coin_units   in   4                coin value in units (1=100, 5=500)
//  sel_valid    in   1                1-cycle strobe, drink selected
//  sel_idx      in   $clog2(N_DRINKS) drink index
//  cancel       in   1                1-cycle strobe, abort and refund
//  valve        out  N_ING            ingredient valves; at most one bit high
//  busy         out  1                high in DISPENSE/CHANGE/DONE
//  credit       out  CREDIT_W         current credit, for the display path
//  coin_reject  out  1                1-cycle pulse, coin refused
//  insufficient out  1                1-cycle pulse, selection refused (price > credit or idx >= N_DRINKS)
//  change_valid out  1                1-cycle pulse, change_units is valid
//  change_units out  CREDIT_W         refund/change amount; holds its value until the next pulse
//  drink_ready  out  1                1-cycle pulse, drink completed
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; credit=0; valve=0; all pulses=0; change_units=0; tick counter=0.
//  States: IDLE(credit==0), CREDIT, DISPENSE, CHANGE, DONE.
//  Coin in IDLE/CREDIT: if credit+coin_units<=MAX_CREDIT, add it next cycle (state->CREDIT); else pulse coin_reject.
//  Coin in DISPENSE/CHANGE/DONE: always pulse coin_reject. Credit is unchanged.
//  Priority within one cycle: cancel > coin > select. A select in the same cycle as cancel or an accepted coin is dropped (no pulse).
//  Cancel in CREDIT: change_units=credit, change_valid pulse, credit=0, ->IDLE. Cancel is ignored in IDLE and while busy.
//  Select in CREDIT with price<=credit: latch drink and price; ->DISPENSE at t+1 with step=0.
//  Select otherwise: insufficient pulse, state held. Select in IDLE: insufficient pulse.
//  DISPENSE: step i=0..N_ING-1 in order.
//   - Recipe secs>0: valve[i]=1 for exactly secs*TICK_DIV cycles. The tick counter clears on step entry.
//   - Recipe secs==0: one cycle with valve=0.
//   - After step N_ING-1: ->CHANGE.
//  CHANGE (1 cycle): change_units=credit-price. change_valid pulses only if the result >0. credit=0. ->DONE.
//  DONE (1 cycle): drink_ready pulse, ->IDLE.
//  Arithmetic: unsigned at CREDIT_W+1 bits, so the overflow check cannot wrap. Change is never negative because price<=credit was checked.
//  Reset mid-dispense: valves drop immediately and credit is lost (no refund).
//  credit output is registered and updates the cycle after a coin is accepted.
// STRUCTURE
//  vending_pkg holds:
//   - state_t enum {IDLE,CREDIT,DISPENSE,CHANGE,DONE};
//   - functions price_of(d) and secs_of(d,i) that slice the packed tables;
//   - coin unit constants COIN_100=1, COIN_500=5.
//  Sub-module sec_tick: TICK_DIV divider with sync clear and tick output, async active-low reset.
//  The FSM, credit register, step index and per-step second counter live in the top module.
// TESTING (sim with TICK_DIV=4; drink0 price 3, recipe {0,0,0,1,2}: water 2s, coffee 1s)
//  1 coin 5 -> credit=5; sel 0 -> valve=00001 for 8 cyc, 00010 for 4 cyc, 3 idle steps;
//    then change_valid with change_units=2; drink_ready next cycle; credit=0.
//  2 coin 1 x2, sel 3 (price 7) -> insufficient pulse, credit stays 2; cancel -> change_units=2, ->IDLE.
//  3 coin 5,5 (credit 10), coin 5 -> coin_reject, credit 10; coin 1 -> credit 11 (MAX); coin 1 -> reject.
//  4 coin 5 and sel 0 in same cycle -> coin accepted, sel dropped; cancel+coin same cycle -> refund, coin dropped.
//  5 coin 1 during DISPENSE -> coin_reject, valves unaffected; rst=0 mid-valve -> valve=0 same cycle, credit=0.
//  6 exact price: coin 1 x3, sel 0 -> no change_valid pulse, drink_ready still pulses.

Source files
------------

// File: rtl/vending_pkg.sv
// ----------------------------------------------------------------------------
// vending_pkg
//   Shared types and helpers for the parametrised drink-vending controller.
//   - state_t      : controller states
//   - COIN_*       : coin values in units of 100 colones
//   - PRICE_DEFAULT / RECIPE_DEFAULT : project default tables
//   - price_of / secs_of : slice one entry out of a packed table
// ----------------------------------------------------------------------------
package vending_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CREDIT,
      DISPENSE,
      CHANGE,
      DONE
   } state_t;

   localparam logic [3:0] COIN_100 = 4'd1;
   localparam logic [3:0] COIN_500 = 4'd5;

   // Tables are handed to the helpers zero-extended to this width so one
   // function serves any parameter set.
   localparam int TBL_MAX_W = 1024;

   // Drink d price lives at [d*8 +: 8]: drink0=3, drink1=4, drink2=5, drink3=7.
   localparam logic [31:0] PRICE_DEFAULT = {8'd7, 8'd5, 8'd4, 8'd3};

   // Each drink is {sugar, choco, milk, coffee, water} seconds, drink0 lowest.
   localparam logic [79:0] RECIPE_DEFAULT = {
      {4'd1, 4'd1, 4'd1, 4'd1, 4'd1},   // drink3: a little of everything
      {4'd1, 4'd2, 4'd0, 4'd0, 4'd2},   // drink2: sweet chocolate
      {4'd0, 4'd0, 4'd2, 4'd1, 4'd1},   // drink1: latte
      {4'd0, 4'd0, 4'd0, 4'd1, 4'd2}    // drink0: black coffee
   };

   function automatic logic [31:0] field_of(input logic [TBL_MAX_W-1:0] tbl,
                                            input int unsigned pos,
                                            input int unsigned w);
      return 32'(tbl >> pos) & ((32'd1 << w) - 32'd1);
   endfunction

   function automatic logic [31:0] price_of(input logic [TBL_MAX_W-1:0] tbl,
                                            input int unsigned d,
                                            input int unsigned credit_w);
      return field_of(tbl, d * credit_w, credit_w);
   endfunction

   function automatic logic [31:0] secs_of(input logic [TBL_MAX_W-1:0] tbl,
                                           input int unsigned d,
                                           input int unsigned i,
                                           input int unsigned n_ing,
                                           input int unsigned step_w);
      return field_of(tbl, (d * n_ing + i) * step_w, step_w);
   endfunction

endpackage

// File: rtl/vending_ctrl_param_sec_tick.sv
// ----------------------------------------------------------------------------
// sec_tick
//   Divides the system clock down to a one-second tick.
//   clk   in  : system clock
//   rst   in  : asynchronous reset, active-low
//   clear in  : synchronous restart of the count (next cycle starts a fresh second)
//   tick  out : high for the last cycle of every TICK_DIV-cycle second
// ----------------------------------------------------------------------------
module sec_tick #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_W'(TICK_DIV - 1));

   // Free-running modulo-TICK_DIV counter; clear restarts the second so a
   // new recipe step always gets full-length seconds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/vending_ctrl_param.sv
// ----------------------------------------------------------------------------
// vending_ctrl_param
//   Parametrised drink-vending controller: accumulates coin credit, accepts a
//   selection against a price table, runs a timed valve recipe, returns change.
//   clk, rst (async active-low)
//   coin_valid/coin_units : coin strobe and value
//   sel_valid/sel_idx     : drink selection strobe and index
//   cancel                : abort and refund the held credit
//   valve                 : one-hot ingredient valves (or all off)
//   busy                  : high while dispensing, giving change, or done
//   credit                : current credit for the display
//   coin_reject, insufficient, change_valid, drink_ready : 1-cycle pulses
//   change_units          : last refund/change amount, held between pulses
// ----------------------------------------------------------------------------
module vending_ctrl_param
   import vending_pkg::*;
#(
   parameter int N_DRINKS   = 4,
   parameter int N_ING      = 5,
   parameter int CREDIT_W   = 8,
   parameter int MAX_CREDIT = 11,
   parameter int STEP_W     = 4,
   parameter int TICK_DIV   = 50_000_000,
   parameter int SEL_W      = (N_DRINKS > 1) ? $clog2(N_DRINKS) : 1,
   parameter logic [N_DRINKS*CREDIT_W-1:0]     PRICE_TABLE  = PRICE_DEFAULT,
   parameter logic [N_DRINKS*N_ING*STEP_W-1:0] RECIPE_TABLE = RECIPE_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_valid,
   input  logic [3:0]          coin_units,
   input  logic                sel_valid,
   input  logic [SEL_W-1:0]    sel_idx,
   input  logic                cancel,
   output logic [N_ING-1:0]    valve,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_reject,
   output logic                insufficient,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_units,
   output logic                drink_ready
);

   localparam int STEP_IW = (N_ING > 1) ? $clog2(N_ING) : 1;

   logic [CREDIT_W-1:0] price_arr [N_DRINKS];
   logic [STEP_W-1:0]   secs_arr  [N_DRINKS][N_ING];

   state_t              state;
   logic [SEL_W-1:0]    drink;
   logic [CREDIT_W-1:0] price;
   logic [STEP_IW-1:0]  step;
   logic [STEP_W-1:0]   sec_cnt;

   logic [CREDIT_W:0]   coin_sum;
   logic [CREDIT_W:0]   change_diff;
   logic                coin_ok;
   logic                sel_in_range;
   logic [CREDIT_W-1:0] sel_price;
   logic                sel_ok;
   logic [STEP_W-1:0]   cur_secs;
   logic [STEP_W-1:0]   next_secs;
   logic [STEP_IW-1:0]  next_step;
   logic                step_last;
   logic                step_done;
   logic                tick;
   logic                tick_clear;

   // Unpack the tables once into arrays so the datapath just indexes them.
   for (genvar d = 0; d < N_DRINKS; d++) begin : g_drink
      assign price_arr[d] = CREDIT_W'(price_of(TBL_MAX_W'(PRICE_TABLE), d, CREDIT_W));
      for (genvar i = 0; i < N_ING; i++) begin : g_ing
         assign secs_arr[d][i] = STEP_W'(secs_of(TBL_MAX_W'(RECIPE_TABLE), d, i, N_ING, STEP_W));
      end
   end

   // Decisions for the current cycle. Credit arithmetic is one bit wider than
   // the register so the MAX_CREDIT comparison cannot wrap.
   always_comb begin
      coin_sum     = {1'b0, credit} + (CREDIT_W+1)'(coin_units);
      coin_ok      = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
      change_diff  = {1'b0, credit} - {1'b0, price};
      sel_in_range = (32'(sel_idx) < N_DRINKS);
      sel_price    = sel_in_range ? price_arr[sel_idx] : '0;
      sel_ok       = sel_in_range && (sel_price <= credit);

      cur_secs   = secs_arr[drink][step];
      step_last  = (step == STEP_IW'(N_ING - 1));
      next_step  = step_last ? step : step + STEP_IW'(1);
      next_secs  = secs_arr[drink][next_step];
      // A zero-second step lasts exactly one cycle; otherwise finish on the
      // tick that completes the last second.
      step_done  = (cur_secs == '0) || (tick && (sec_cnt + STEP_W'(1) == cur_secs));
      tick_clear = (state != DISPENSE) || step_done;
   end

   sec_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_sec_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (tick_clear),
      .tick  (tick)
   );

   // Controller FSM with all outputs registered. Pulses default low and are
   // raised for a single cycle. Within IDLE/CREDIT, cancel beats coin beats
   // select; a rejected coin does not hide a select in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         credit       <= '0;
         price        <= '0;
         drink        <= '0;
         step         <= '0;
         sec_cnt      <= '0;
         valve        <= '0;
         busy         <= 1'b0;
         coin_reject  <= 1'b0;
         insufficient <= 1'b0;
         change_valid <= 1'b0;
         change_units <= '0;
         drink_ready  <= 1'b0;
      end else begin
         coin_reject  <= 1'b0;
         insufficient <= 1'b0;
         change_valid <= 1'b0;
         drink_ready  <= 1'b0;

         case (state)
            IDLE, CREDIT: begin
               if (cancel) begin
                  if (state == CREDIT) begin
                     change_units <= credit;
                     change_valid <= 1'b1;
                     credit       <= '0;
                     state        <= IDLE;
                  end
               end else if (coin_valid && coin_ok) begin
                  credit <= coin_sum[CREDIT_W-1:0];
                  if (coin_sum != '0) begin
                     state <= CREDIT;
                  end
               end else begin
                  if (coin_valid) begin
                     coin_reject <= 1'b1;
                  end
                  if (sel_valid) begin
                     if ((state == CREDIT) && sel_ok) begin
                        drink   <= sel_idx;
                        price   <= sel_price;
                        step    <= '0;
                        sec_cnt <= '0;
                        valve   <= (secs_arr[sel_idx][0] != '0) ? N_ING'(1) : '0;
                        busy    <= 1'b1;
                        state   <= DISPENSE;
                     end else begin
                        insufficient <= 1'b1;
                     end
                  end
               end
            end

            DISPENSE: begin
               if (coin_valid) begin
                  coin_reject <= 1'b1;
               end
               if (step_done) begin
                  sec_cnt <= '0;
                  if (step_last) begin
                     valve <= '0;
                     state <= CHANGE;
                  end else begin
                     step  <= next_step;
                     valve <= (next_secs != '0) ? (N_ING'(1) << next_step) : '0;
                  end
               end else if (tick) begin
                  sec_cnt <= sec_cnt + STEP_W'(1);
               end
            end

            CHANGE: begin
               if (coin_valid) begin
                  coin_reject <= 1'b1;
               end
               change_units <= CREDIT_W'(change_diff);
               change_valid <= (change_diff != '0);
               credit       <= '0;
               state        <= DONE;
            end

            DONE: begin
               if (coin_valid) begin
                  coin_reject <= 1'b1;
               end
               drink_ready <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
